// File: rtl/serializer_pkg.sv
// Shared types and helpers for the byte serializer and its input FIFO.
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    localparam string LSB_FIRST = "LSB_FIRST";
    localparam string MSB_FIRST = "MSB_FIRST";

    // Width of a counter that must be able to hold max_value.
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Parallel-in handshake plus serial-out bundle of the byte serializer.
interface byte_serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  load;
    logic                  load_vlaue;
    logic                  busy;
    logic                  frame_done;
    logic [CNT_W-1:0]      fifo_count;

    modport master (
        output in_valid, in_data,
        input  in_ready, load, load_vlaue, busy, frame_done, fifo_count
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, load, load_vlaue, busy, frame_done, fifo_count
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered count/full/empty flags (DEPTH a power of 2).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && !empty_q;
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    // NOTE: storage is not reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign rdata = mem_q[rptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/byte_serializer.sv
// Buffers parallel bytes and shifts them out one bit per clock on load/load_vlaue.
// Optional even-parity trailer bit: define BYTE_SERIALIZER_PARITY_EN.
module byte_serializer
    import serializer_pkg::*;
#(
    parameter int    DATA_WIDTH = 8,
    parameter int    FIFO_DEPTH = 4,
    parameter string BIT_ORDER  = LSB_FIRST,
    parameter int    IDLE_GAP   = 0
) (
    input logic              clk,
    input logic              rst,
    byte_serializer_if.slave bus
);
    localparam bit MSB_ORDER = (BIT_ORDER == MSB_FIRST);
`ifdef BYTE_SERIALIZER_PARITY_EN
    localparam int LAST_POS = DATA_WIDTH;
`else
    localparam int LAST_POS = DATA_WIDTH - 1;
`endif
    localparam int BCNT_W = cnt_width(LAST_POS);
    localparam int GCNT_W = cnt_width(IDLE_GAP);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] sbuf_q;
    logic [BCNT_W-1:0]     bcnt_q;
    logic [GCNT_W-1:0]     gcnt_q;
    logic                  load_q;
    logic                  bit_q;
    logic                  done_q;
    logic                  busy_q;

    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      count_nxt;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  frame_last;
    logic                  gap_last;
    logic [DATA_WIDTH-1:0] ordered;
    logic                  data_bit;
    logic                  serial_bit;

    sync_fifo #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata(bus.in_data),
        .rdata(fifo_rdata),
        .count(fifo_count),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign push       = bus.in_valid && !fifo_full;
    assign frame_last = (state_q == SHIFT) && (bcnt_q == BCNT_W'(LAST_POS));
    assign gap_last   = (state_q == GAP) && (gcnt_q == GCNT_W'(IDLE_GAP - 1));
    // A new frame is fetched from IDLE, straight off a frame end, or when a gap expires.
    assign pop        = !fifo_empty &&
                        ((state_q == IDLE) || (frame_last && (IDLE_GAP == 0)) || gap_last);
    assign count_nxt  = fifo_count + CNT_W'(push) - CNT_W'(pop);

    // NOTE: defaults first in always_comb so no path leaves a signal unassigned (latch).
    always_comb begin
        ordered  = sbuf_q;
        data_bit = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            ordered[i] = MSB_ORDER ? sbuf_q[DATA_WIDTH-1-i] : sbuf_q[i];
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bcnt_q == BCNT_W'(i)) begin
                data_bit = ordered[i];
            end
        end
    end

`ifdef BYTE_SERIALIZER_PARITY_EN
    assign serial_bit = (bcnt_q == BCNT_W'(DATA_WIDTH)) ? ^sbuf_q : data_bit;
`else
    assign serial_bit = data_bit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sbuf_q  <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            load_q  <= 1'b0;
            bit_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        sbuf_q  <= fifo_rdata;
                        bcnt_q  <= '0;
                        state_q <= SHIFT;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q <= (count_nxt != '0);
                    end
                end
                SHIFT: begin
                    load_q <= 1'b1;
                    bit_q  <= serial_bit;
                    bcnt_q <= bcnt_q + BCNT_W'(1);
                    busy_q <= 1'b1;
                    if (frame_last) begin
                        done_q <= 1'b1;
                        if (IDLE_GAP > 0) begin
                            state_q <= GAP;
                            gcnt_q  <= '0;
                        end else if (pop) begin
                            sbuf_q <= fifo_rdata;
                            bcnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= (count_nxt != '0);
                        end
                    end
                end
                GAP: begin
                    gcnt_q <= gcnt_q + GCNT_W'(1);
                    busy_q <= 1'b1;
                    if (gap_last) begin
                        if (pop) begin
                            sbuf_q  <= fifo_rdata;
                            bcnt_q  <= '0;
                            state_q <= SHIFT;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= (count_nxt != '0);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.load       = load_q;
    assign bus.load_vlaue = bit_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: LSB/gap-0, MSB/gap-0 and LSB/gap-3 instances share one stimulus.
module tb_byte_serializer;
`ifdef BYTE_SERIALIZER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif
    localparam int GAPN = 3;

    typedef struct {
        logic [7:0] data;
        logic [7:0] lsb_seq;  // bit i = i-th transmitted bit
        logic [7:0] msb_seq;
        logic       par;
    } vec_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    int         total    = 0;
    int         bad      = 0;

    vec_t       vecs [6];
    logic [7:0] tx   [6];
    logic [7:0] rx   [8];
    int         ovf_k, ovf_nrx, ovf_nb, viol, loads_after;
    logic       full_seen;
    logic [8:0] cur;

    always #5 clk = ~clk;

    byte_serializer_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) if_lsb ();
    byte_serializer_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) if_msb ();
    byte_serializer_if #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) if_gap ();

    assign if_lsb.in_valid = in_valid;
    assign if_lsb.in_data  = in_data;
    assign if_msb.in_valid = in_valid;
    assign if_msb.in_data  = in_data;
    assign if_gap.in_valid = in_valid;
    assign if_gap.in_data  = in_data;

    byte_serializer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .BIT_ORDER("LSB_FIRST"), .IDLE_GAP(0))
        u_lsb (.clk(clk), .rst(rst), .bus(if_lsb));
    byte_serializer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .BIT_ORDER("MSB_FIRST"), .IDLE_GAP(0))
        u_msb (.clk(clk), .rst(rst), .bus(if_msb));
    byte_serializer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .BIT_ORDER("LSB_FIRST"), .IDLE_GAP(GAPN))
        u_gap (.clk(clk), .rst(rst), .bus(if_gap));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vector(input vec_t v);
        logic [8:0] got_l, got_m, got_g, ld_l, ld_m, ld_g, dn_l, dn_m, dn_g;
        logic [8:0] want_l, want_m;
        got_l = '0; got_m = '0; got_g = '0;
        ld_l  = '0; ld_m  = '0; ld_g  = '0;
        dn_l  = '0; dn_m  = '0; dn_g  = '0;
`ifdef BYTE_SERIALIZER_PARITY_EN
        want_l = {v.par, v.lsb_seq};
        want_m = {v.par, v.msb_seq};
`else
        want_l = {1'b0, v.lsb_seq};
        want_m = {1'b0, v.msb_seq};
`endif
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v.data;
        @(negedge clk);
        in_valid = 1'b0;
        check("vec count after push", if_lsb.fifo_count, 1);
        @(negedge clk);
        check("vec latency load", {if_lsb.load, if_msb.load, if_gap.load}, 0);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            got_l[i] = if_lsb.load_vlaue; ld_l[i] = if_lsb.load; dn_l[i] = if_lsb.frame_done;
            got_m[i] = if_msb.load_vlaue; ld_m[i] = if_msb.load; dn_m[i] = if_msb.frame_done;
            got_g[i] = if_gap.load_vlaue; ld_g[i] = if_gap.load; dn_g[i] = if_gap.frame_done;
        end
        check("vec lsb bits", got_l, want_l);
        check("vec msb bits", got_m, want_m);
        check("vec gap-inst bits", got_g, want_l);
        check("vec load run", {ld_l, ld_m, ld_g}, {3{9'((1 << FL) - 1)}});
        check("vec done pos", {dn_l, dn_m, dn_g}, {3{9'(1 << (FL - 1))}});
        @(negedge clk);
        check("vec frame end", {if_lsb.load, if_msb.load, if_gap.load,
                                if_lsb.frame_done, if_msb.frame_done, if_gap.frame_done}, 0);
        repeat (4) @(negedge clk);
        check("vec idle busy", {if_lsb.busy, if_msb.busy, if_gap.busy}, 0);
    endtask

    task automatic run_burst();
        logic [7:0]  bdat [3];
        logic [63:0] rl0, rb0, rd0, rl3, rb3, rd3;
        logic [63:0] el0, eb0, ed0, el3, eb3, ed3;
        int          c0, c3;
        bdat = '{8'hFF, 8'h00, 8'hAA};   // all three have even parity 0
        rl0 = '0; rb0 = '0; rd0 = '0; rl3 = '0; rb3 = '0; rd3 = '0;
        el0 = '0; eb0 = '0; ed0 = '0; el3 = '0; eb3 = '0; ed3 = '0;
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < FL; p++) begin
                c0 = 2 + k * FL + p;
                c3 = 2 + k * (FL + GAPN) + p;
                el0[c0] = 1'b1;
                el3[c3] = 1'b1;
                if (p < 8) begin
                    eb0[c0] = bdat[k][p];
                    eb3[c3] = bdat[k][p];
                end
                if (p == FL - 1) begin
                    ed0[c0] = 1'b1;
                    ed3[c3] = 1'b1;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (c == 0) in_data = 8'h00;
            if (c == 1) in_data = 8'hAA;
            if (c == 2) in_valid = 1'b0;
            rl0[c] = if_lsb.load; rb0[c] = if_lsb.load_vlaue; rd0[c] = if_lsb.frame_done;
            rl3[c] = if_gap.load; rb3[c] = if_gap.load_vlaue; rd3[c] = if_gap.frame_done;
        end
        check("burst gap0 load", rl0, el0);
        check("burst gap0 bits", rb0 & el0, eb0);
        check("burst gap0 done", rd0, ed0);
        check("burst gap3 load", rl3, el3);
        check("burst gap3 bits", rb3 & el3, eb3);
        check("burst gap3 done", rd3, ed3);
    endtask

    initial begin
        vecs[0] = '{data: 8'h1E, lsb_seq: 8'h1E, msb_seq: 8'h78, par: 1'b0};
        vecs[1] = '{data: 8'h07, lsb_seq: 8'h07, msb_seq: 8'hE0, par: 1'b1};
        vecs[2] = '{data: 8'h12, lsb_seq: 8'h12, msb_seq: 8'h48, par: 1'b0};
        vecs[3] = '{data: 8'h80, lsb_seq: 8'h80, msb_seq: 8'h01, par: 1'b1};
        vecs[4] = '{data: 8'hC5, lsb_seq: 8'hC5, msb_seq: 8'hA3, par: 1'b0};
        vecs[5] = '{data: 8'hFF, lsb_seq: 8'hFF, msb_seq: 8'hFF, par: 1'b0};
        tx = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        // Reset held with in_valid high: nothing may enter the FIFO.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst load", {if_lsb.load, if_msb.load, if_gap.load}, 0);
        check("rst in_ready", {if_lsb.in_ready, if_msb.in_ready, if_gap.in_ready}, 3'b111);
        check("rst fifo_count", {if_lsb.fifo_count, if_msb.fifo_count, if_gap.fifo_count}, 0);
        check("rst busy/done", {if_lsb.busy, if_lsb.frame_done, if_lsb.load_vlaue}, 0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post-rst fifo_count", {if_lsb.fifo_count, if_msb.fifo_count, if_gap.fifo_count}, 0);
        check("post-rst load/busy", {if_lsb.load, if_lsb.busy, if_gap.busy}, 0);

        foreach (vecs[i]) run_vector(vecs[i]);

        do_reset();
        run_burst();

        // Overflow: six bytes offered back to back against a 4-deep FIFO.
        do_reset();
        ovf_k = 0; ovf_nrx = 0; ovf_nb = 0; viol = 0; full_seen = 1'b0; cur = '0;
        fork
            begin
                int guard = 0;
                @(negedge clk);
                while (ovf_k < 6 && guard < 200) begin
                    in_valid = 1'b1;
                    in_data  = tx[ovf_k];
                    if (if_lsb.in_ready) ovf_k++;
                    @(negedge clk);
                    guard++;
                end
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 120; c++) begin
                    @(negedge clk);
                    if (if_lsb.fifo_count == 3'd4) full_seen = 1'b1;
                    if ((if_lsb.fifo_count == 3'd4) && if_lsb.in_ready) viol++;
                    if (if_lsb.fifo_count > 3'd4) viol++;
                    if (if_lsb.load && ovf_nb < 9) begin
                        cur[ovf_nb] = if_lsb.load_vlaue;
                        ovf_nb++;
                    end
                    if (if_lsb.frame_done) begin
                        if (ovf_nrx < 8) rx[ovf_nrx] = cur[7:0];
                        ovf_nrx++;
                        ovf_nb = 0;
                    end
                end
            end
        join
        check("ovf all sent", ovf_k, 6);
        check("ovf rx count", ovf_nrx, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < ovf_nrx) check("ovf order", rx[i], tx[i]);
        end
        check("ovf full seen", full_seen, 1);
        check("ovf ready while full", viol, 0);

        // Reset after the third bit of a frame with two bytes still queued.
        do_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        @(negedge clk);
        in_data = 8'h81;
        @(negedge clk);
        in_data = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst pre load", if_lsb.load, 1);
        check("midrst pre count", if_lsb.fifo_count, 2);
        rst = 1'b1;
        @(negedge clk);
        check("midrst load/done", {if_lsb.load, if_lsb.frame_done, if_msb.load, if_gap.load}, 0);
        check("midrst count/busy", {if_lsb.fifo_count, if_lsb.busy}, 0);
        check("midrst in_ready", if_lsb.in_ready, 1);
        rst = 1'b0;
        loads_after = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (if_lsb.load || if_lsb.frame_done) loads_after++;
        end
        check("midrst frame lost", loads_after, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
Upstream feeder for the team's serial-in/parallel-out shift register. Accepts parallel bytes over a valid/ready handshake and buffers them in a small FIFO. Drives them out one bit per clock on the shift register's `load`/`load_vlaue` inputs, with configurable bit order and inter-frame gap.

Parameters:
DATA_WIDTH, 8, bits per frame
FIFO_DEPTH, 4, input buffer entries (power of 2, >=2)
BIT_ORDER, "LSB_FIRST", "LSB_FIRST" or "MSB_FIRST" serial order
IDLE_GAP, 0, cycles with load=0 inserted after each frame (0..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream byte valid
in_data  input  DATA_WIDTH  upstream byte
in_ready  output  1  FIFO not full
load  output  1  serial bit valid to shift register
load_vlaue  output  1  serial data bit to shift register
busy  output  1  state != IDLE or FIFO non-empty
frame_done  output  1  one-cycle pulse with the last bit of a frame
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Single clock `clk`. Synchronous active-high `rst`. All outputs are registered.
- Reset values: load=0, load_vlaue=0, frame_done=0, busy=0, fifo_count=0, in_ready=1, state=IDLE. FIFO pointers are cleared.
- Push: a byte is written when in_valid && in_ready. in_ready = (fifo_count != FIFO_DEPTH).
- Push and pop in the same cycle leave fifo_count unchanged.
- When full, in_ready=0 and in_data is ignored.
- FSM states:
  - IDLE: load=0. If the FIFO is non-empty, pop into shift buffer sbuf, clear bit counter bcnt, go to SHIFT.
  - SHIFT: load=1. load_vlaue = sbuf bit selected by BIT_ORDER (bit bcnt for LSB_FIRST, bit DATA_WIDTH-1-bcnt for MSB_FIRST). bcnt increments each cycle.
    - At bcnt=DATA_WIDTH-1, frame_done=1.
    - Next state is GAP if IDLE_GAP>0.
    - Otherwise, if the FIFO is non-empty, pop and stay in SHIFT. Back-to-back frames have no bubble.
    - Otherwise go to IDLE.
  - GAP: load=0 for exactly IDLE_GAP cycles (gcnt counter), then the same decision as the end of SHIFT (pop and go to SHIFT, or go to IDLE).
- Latency: byte accepted at edge t into an empty FIFO while IDLE. Popped at edge t+1. First bit is valid on load/load_vlaue after edge t+2. The frame occupies DATA_WIDTH consecutive load=1 cycles.
- load_vlaue holds its last value when load=0. Consumers must qualify it with load.
- rst asserted mid-frame aborts immediately: the frame is lost, the FIFO is flushed, and outputs return to reset values on the next edge.
- in_valid while rst=1 is not accepted.

Optional Feature:
- Macro: BYTE_SERIALIZER_PARITY_EN.
- Defined: after the data bits, one extra SHIFT cycle outputs even parity (XOR of all DATA_WIDTH bits) with load=1. frame_done moves to the parity cycle, and a frame is DATA_WIDTH+1 cycles.
- Undefined: no parity logic; a frame is DATA_WIDTH cycles.

Decomposition:
- Package serializer_pkg holds:
  - state enum {IDLE, SHIFT, GAP};
  - BIT_ORDER string constants LSB_FIRST and MSB_FIRST;
  - a function computing counter widths.
- One sub-module: sync_fifo, with parameters WIDTH and DEPTH and ports clk, rst, push, pop, wdata, rdata, count, full, empty. It is instantiated once for the input buffer.

Test Plan:
1. Reset: rst=1 for 3 cycles with in_valid=1 -> load=0, in_ready=1, fifo_count=0, nothing accepted after release.
2. LSB_FIRST, write 0x1E once -> two cycles later load=1 for 8 cycles, load_vlaue = 0,1,1,1,1,0,0,0, frame_done on the 8th, then IDLE.
3. MSB_FIRST, write 0x1E -> load_vlaue = 0,0,0,1,1,1,1,0.
4. IDLE_GAP=0, burst of 0xFF,0x00,0xAA -> 24 contiguous load=1 cycles, three frame_done pulses 8 cycles apart. With IDLE_GAP=3 -> exactly 3 load=0 cycles between frames.
5. Hold in_valid=1 with 6 bytes, FIFO_DEPTH=4 -> in_ready drops when fifo_count=4. No byte is lost or duplicated, and output order matches input order.
6. rst mid-frame after the 3rd bit with 2 bytes queued -> next cycle load=0, fifo_count=0, no frame_done. Under BYTE_SERIALIZER_PARITY_EN, 0x07 -> 9th bit = 1.
